// File: rtl/rmon_counter_engine.sv
// rtl/rmon_counter_engine.sv - RMON counter RAM port-A master: post-reset clear sweep,
// arbitrated Rx/Tx increments and CPU read-and-clear as 4-cycle read-modify-write.
module rmon_counter_engine #(
    parameter int DEPTH_LOG2 = 6,
    parameter int INC_WIDTH  = 16,
    parameter int SATURATE   = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Rx_apply,
    input  logic [DEPTH_LOG2-2:0] Rx_addr,
    input  logic [INC_WIDTH-1:0]  Rx_inc,
    output logic                  Rx_ack,
    input  logic                  Tx_apply,
    input  logic [DEPTH_LOG2-2:0] Tx_addr,
    input  logic [INC_WIDTH-1:0]  Tx_inc,
    output logic                  Tx_ack,
    input  logic                  Cpu_clr_apply,
    input  logic [DEPTH_LOG2-1:0] Cpu_clr_addr,
    output logic [31:0]           Cpu_clr_data,
    output logic                  Cpu_clr_done,
    output logic                  Init_busy,
    output logic [DEPTH_LOG2-1:0] Addra,
    output logic [31:0]           Dina,
    output logic                  Wea,
    input  logic [31:0]           Douta
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WAIT, S_WR} state_t;

    state_t                  state_q;
    logic [DEPTH_LOG2-1:0]   addra_q;
    logic [31:0]             dina_q;
    logic                    wea_q;
    logic                    rx_ack_q;
    logic                    tx_ack_q;
    logic                    clr_done_q;
    logic [31:0]             clr_data_q;
    logic                    busy_q;
    logic [INC_WIDTH-1:0]    inc_q;
    logic                    is_clr_q;
    logic                    last_tx_q;

    logic [32:0]             sum_d;
    logic [31:0]             wr_data_d;
    logic                    pick_rx_d;

    always_comb begin
        sum_d     = {1'b0, Douta} + {1'b0, {(32-INC_WIDTH){1'b0}}, inc_q};
        wr_data_d = (SATURATE != 0 && sum_d[32]) ? 32'hFFFF_FFFF : sum_d[31:0];
        // Rx wins a tie only if Tx was the last one served.
        pick_rx_d = Rx_apply && (!Tx_apply || last_tx_q);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_INIT;
            addra_q    <= '0;
            dina_q     <= '0;
            wea_q      <= 1'b0;
            rx_ack_q   <= 1'b0;
            tx_ack_q   <= 1'b0;
            clr_done_q <= 1'b0;
            clr_data_q <= '0;
            busy_q     <= 1'b1;
            inc_q      <= '0;
            is_clr_q   <= 1'b0;
            last_tx_q  <= 1'b1;
        end else begin
            rx_ack_q   <= 1'b0;
            tx_ack_q   <= 1'b0;
            clr_done_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    // wea_q doubles as the "sweep started" flag on the first cycle.
                    if (!wea_q) begin
                        wea_q   <= 1'b1;
                        addra_q <= '0;
                    end else if (addra_q == {DEPTH_LOG2{1'b1}}) begin
                        wea_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        addra_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        addra_q <= addra_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (Cpu_clr_apply) begin
                        addra_q  <= Cpu_clr_addr;
                        inc_q    <= '0;
                        is_clr_q <= 1'b1;
                        state_q  <= S_RD;
                    end else if (pick_rx_d) begin
                        addra_q   <= {1'b0, Rx_addr};
                        inc_q     <= Rx_inc;
                        is_clr_q  <= 1'b0;
                        rx_ack_q  <= 1'b1;
                        last_tx_q <= 1'b0;
                        state_q   <= S_RD;
                    end else if (Tx_apply) begin
                        addra_q   <= {1'b1, Tx_addr};
                        inc_q     <= Tx_inc;
                        is_clr_q  <= 1'b0;
                        tx_ack_q  <= 1'b1;
                        last_tx_q <= 1'b1;
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    wea_q   <= 1'b1;
                    state_q <= S_WR;
                    if (is_clr_q) begin
                        dina_q     <= '0;
                        clr_data_q <= Douta;
                        clr_done_q <= 1'b1;
                    end else begin
                        dina_q <= wr_data_d;
                    end
                end
                S_WR: begin
                    wea_q   <= 1'b0;
                    dina_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wea_q   <= 1'b0;
                    dina_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Addra        = addra_q;
    assign Dina         = dina_q;
    assign Wea          = wea_q;
    assign Rx_ack       = rx_ack_q;
    assign Tx_ack       = tx_ack_q;
    assign Cpu_clr_done = clr_done_q;
    assign Cpu_clr_data = clr_data_q;
    assign Init_busy    = busy_q;

endmodule

// File: tb/tb_rmon_counter_engine.sv
// tb/tb_rmon_counter_engine.sv - directed scoreboard bench for rmon_counter_engine,
// one wrapping and one saturating instance sharing the same request stimulus.
module tb_rmon_counter_engine;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        Rx_apply, Tx_apply, Cpu_clr_apply;
    logic [4:0]  Rx_addr, Tx_addr;
    logic [15:0] Rx_inc, Tx_inc;
    logic [5:0]  Cpu_clr_addr;

    logic        rx_ack0, tx_ack0, clr_done0, busy0, wea0;
    logic        rx_ack1, tx_ack1, clr_done1, busy1, wea1;
    logic [31:0] clr_data0, dina0, douta0, clr_data1, dina1, douta1;
    logic [5:0]  addra0, addra1;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [31:0] pl_val = '0;

    rmon_counter_engine #(.DEPTH_LOG2(6), .INC_WIDTH(16), .SATURATE(0)) u_wrap (
        .Clk(Clk), .Reset(Reset),
        .Rx_apply(Rx_apply), .Rx_addr(Rx_addr), .Rx_inc(Rx_inc), .Rx_ack(rx_ack0),
        .Tx_apply(Tx_apply), .Tx_addr(Tx_addr), .Tx_inc(Tx_inc), .Tx_ack(tx_ack0),
        .Cpu_clr_apply(Cpu_clr_apply), .Cpu_clr_addr(Cpu_clr_addr),
        .Cpu_clr_data(clr_data0), .Cpu_clr_done(clr_done0), .Init_busy(busy0),
        .Addra(addra0), .Dina(dina0), .Wea(wea0), .Douta(douta0)
    );

    rmon_counter_engine #(.DEPTH_LOG2(6), .INC_WIDTH(16), .SATURATE(1)) u_sat (
        .Clk(Clk), .Reset(Reset),
        .Rx_apply(Rx_apply), .Rx_addr(Rx_addr), .Rx_inc(Rx_inc), .Rx_ack(rx_ack1),
        .Tx_apply(Tx_apply), .Tx_addr(Tx_addr), .Tx_inc(Tx_inc), .Tx_ack(tx_ack1),
        .Cpu_clr_apply(Cpu_clr_apply), .Cpu_clr_addr(Cpu_clr_addr),
        .Cpu_clr_data(clr_data1), .Cpu_clr_done(clr_done1), .Init_busy(busy1),
        .Addra(addra1), .Dina(dina1), .Wea(wea1), .Douta(douta1)
    );

    always @(posedge Clk) begin
        if (wea0) mem0[addra0] <= dina0;
        if (wea1) mem1[addra1] <= dina1;
        douta0 <= mem0[addra0];
        douta1 <= mem1[addra1];
        if (pl_en) begin
            mem0[pl_addr] <= pl_val;
            mem1[pl_addr] <= pl_val;
        end
    end

    int checks = 0, errors = 0, cyc = 0, last_ack = 0;
    int rx_left = 0, tx_left = 0;
    bit rx_walk = 1'b0;
    int exp_q[$];
    logic [31:0] clr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take(input int src);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("ack_source", src, e);
        if (last_ack != 0) chk("ack_spacing", cyc - last_ack, 4);
        last_ack = cyc;
    endtask

    task automatic step();
        logic [31:0] ed;
        int e;
        @(negedge Clk);
        cyc++;
        if (clr_done0) begin
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            ed = (clr_q.size() > 0) ? clr_q.pop_front() : 32'hBAD0_BAD0;
            chk("clr_order", 2, e);
            chk("clr_data", clr_data0, ed);
            chk("clr_wr_en", 32'(wea0), 1);
            chk("clr_wr_data", dina0, 0);
            chk("clr_wr_addr", 32'(addra0), 32'(Cpu_clr_addr));
            Cpu_clr_apply = 1'b0;
        end
        if (rx_ack0) begin
            take(0);
            rx_left--;
            if (rx_left == 0) Rx_apply = 1'b0;
            else if (rx_walk) Rx_addr = Rx_addr + 5'd1;
        end
        if (tx_ack0) begin
            take(1);
            tx_left--;
            if (tx_left == 0) Tx_apply = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((Rx_apply || Tx_apply || Cpu_clr_apply || exp_q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < 400) ? 32'd1 : 32'd0, 1);
        repeat (4) step();
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] v);
        @(negedge Clk);
        pl_en = 1'b1; pl_addr = a; pl_val = v;
        @(negedge Clk);
        pl_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Rx_apply = 1'b0; Tx_apply = 1'b0; Cpu_clr_apply = 1'b0;
        Rx_addr = '0; Tx_addr = '0; Rx_inc = '0; Tx_inc = '0; Cpu_clr_addr = '0;
        for (int i = 0; i < 64; i++) preload(6'(i), 32'hDEAD_BEEF);

        chk("rst_wea", 32'(wea0), 0);
        chk("rst_busy", 32'(busy0), 1);
        chk("rst_addra", 32'(addra0), 0);
        chk("rst_dina", dina0, 0);
        chk("rst_rx_ack", 32'(rx_ack0), 0);
        chk("rst_tx_ack", 32'(tx_ack0), 0);
        chk("rst_clr_done", 32'(clr_done0), 0);
        chk("rst_clr_data", clr_data0, 0);

        // Rx request raised during the sweep must wait for it to finish.
        Rx_addr = 5'd5; Rx_inc = 16'd64; rx_left = 3; Rx_apply = 1'b1;
        repeat (3) exp_q.push_back(0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("init_busy", 32'(busy0), 1);
            chk("init_wea", 32'(wea0), 1);
            chk("init_addra", 32'(addra0), i);
            chk("init_dina", dina0, 0);
            chk("init_no_ack", 32'(rx_ack0), 0);
        end
        step();
        chk("init_done_busy", 32'(busy0), 0);
        chk("init_done_wea", 32'(wea0), 0);
        drain();
        for (int i = 0; i < 64; i++) chk("sweep_mem", mem0[i], (i == 5) ? 32'd192 : 32'd0);
        chk("tx_side_untouched", mem0[37], 0);

        // CPU clear beats Rx and Tx; Rx wins the tie after a Tx service.
        last_ack = 0;
        Tx_addr = 5'd3; Tx_inc = 16'd7; tx_left = 1; Tx_apply = 1'b1;
        exp_q.push_back(1);
        drain();
        chk("tx_preload", mem0[35], 7);
        last_ack = 0;
        exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
        clr_q.push_back(32'd7);
        Rx_addr = 5'd3; Rx_inc = 16'd1; rx_left = 1; Rx_apply = 1'b1;
        Tx_addr = 5'd3; Tx_inc = 16'd2; tx_left = 1; Tx_apply = 1'b1;
        Cpu_clr_addr = 6'd35; Cpu_clr_apply = 1'b1;
        drain();
        chk("mix_rx_mem", mem0[3], 1);
        chk("mix_tx_mem", mem0[35], 2);
        chk("mix_tx_mem_sat", mem1[35], 2);

        // Wrap versus saturate at the top of the 32-bit range.
        last_ack = 0;
        preload(6'd7, 32'hFFFF_FFFE);
        Rx_addr = 5'd7; Rx_inc = 16'd3; rx_left = 1; Rx_apply = 1'b1;
        exp_q.push_back(0);
        drain();
        chk("wrap_result", mem0[7], 32'd1);
        chk("sat_result", mem1[7], 32'hFFFF_FFFF);

        // Zero increment leaves the counter intact.
        last_ack = 0;
        Rx_addr = 5'd5; Rx_inc = 16'd0; rx_left = 1; Rx_apply = 1'b1;
        exp_q.push_back(0);
        drain();
        chk("zero_inc", mem0[5], 192);

        // Reset while an RMW is in its WAIT cycle.
        last_ack = 0;
        Rx_addr = 5'd10; Rx_inc = 16'd100; rx_left = 1; Rx_apply = 1'b1;
        exp_q.push_back(0);
        drain();
        chk("pre_reset_val", mem0[10], 100);
        last_ack = 0;
        Rx_inc = 16'd5; rx_left = 1; Rx_apply = 1'b1;
        exp_q.push_back(0);
        for (int n = 0; n < 20 && Rx_apply; n++) step();
        chk("rmw_ack_seen", 32'(Rx_apply), 0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        chk("async_wea", 32'(wea0), 0);
        chk("async_busy", 32'(busy0), 1);
        chk("async_addra", 32'(addra0), 0);
        @(negedge Clk);
        Reset = 1'b0;
        last_ack = 0;
        step();
        chk("resweep_start_addr", 32'(addra0), 0);
        chk("resweep_start_wea", 32'(wea0), 1);
        repeat (64) step();
        chk("resweep_done", 32'(busy0), 0);
        step();
        chk("reset_cleared_ctr", mem0[10], 0);
        chk("reset_cleared_other", mem0[5], 0);

        // Rx and Tx held together: strict alternation, no starvation.
        last_ack = 0;
        Rx_addr = 5'd0; Rx_inc = 16'd1; rx_walk = 1'b1; rx_left = 10; Rx_apply = 1'b1;
        Tx_addr = 5'd0; Tx_inc = 16'd1; tx_left = 10; Tx_apply = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(0);
            exp_q.push_back(1);
        end
        drain();
        chk("rr_rx_first", mem0[0], 1);
        chk("rr_rx_last", mem0[9], 1);
        chk("rr_rx_beyond", mem0[10], 0);
        chk("rr_tx_total", mem0[32], 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
